vector_run_ctrl: RTL and testbench
==================================

Name: vector_run_ctrl

Overview:
Sequencer that prepares and launches one kernel run on the vector CPU. It streams pixel quads and multiplier-coefficient quads from an upstream source into the CPU register-file write ports, holds the CPU in reset while loading, then releases it and counts window-output-memory writes until the run completes. It also drains the pipeline, re-asserts CPU reset, and reports done or timeout. It sits between the system loader/DMA and the vector CPU top.

Parameters:
NUM_PXL, 2, pixel quads per run (register positions 0..NUM_PXL-1; wr_pos_pxl uses bit 0 of index)
NUM_MUL, 2, coefficient quads per run (wr_mul_pos uses bit 0 of index)
EXP_WOM, 64, WOM writes that mark run completion (1..65535)
DRAIN_CYC, 4, cycles CPU stays running after last WOM write (pipeline depth)
TIMEOUT, 4096, maximum RUN-state cycles before error

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
start  in  1  pulse; begins a run from IDLE, DONE or ERR
src_valid  in  1  upstream quad valid
src_data  in  128  quad; [31:0]->lane1 … [127:96]->lane4
src_ready  out  1  controller accepts quad
we_pxl  out  1  pixel register write strobe
wr_pos_pxl  out  1  pixel register position
wdp  out  128  pixel write data (lanes as src_data)
we_mul  out  1  coefficient register write strobe
wr_mul_pos  out  1  coefficient register position
wdm  out  128  coefficient write data
cpu_rst  out  1  reset to vector CPU
wom_we  in  1  CPU memory-stage WOM write strobe
wom_count  out  16  WOM writes in current run
busy  out  1  high in LOAD_PXL/LOAD_MUL/RUN/DRAIN
done  out  1  high in DONE
timeout_err  out  1  high in ERR

Behaviour:
- Reset: state=IDLE; cpu_rst=1; src_ready, we_pxl, we_mul, wr_pos_pxl, wr_mul_pos, busy, done, timeout_err=0; wdp, wdm, wom_count, idx, cycle counter=0. rst mid-operation aborts the run; reset values appear after the next edge.
- IDLE: cpu_rst=1. On start, go to LOAD_PXL with idx=0 and wom_count=0.
- LOAD_PXL: src_ready=1 (combinational from state). A handshake (src_valid&src_ready) registers src_data into wdp, wr_pos_pxl=idx[0], and sets we_pxl=1 for exactly the next cycle. Write latency is 1 cycle. After NUM_PXL handshakes, go to LOAD_MUL with idx=0. Back-to-back handshakes are allowed, one per cycle. When src_valid is low, the controller waits with no strobe.
- LOAD_MUL: same rules, using wdm, wr_mul_pos, we_mul. After NUM_MUL handshakes, go to RUN and clear the cycle counter. src_ready=0 in all other states.
- The write for the final load handshake completes in the first RUN cycle. cpu_rst stays 1 during that cycle and falls on the following edge.
- RUN: each cycle with wom_we=1 increments wom_count (saturating at 0xFFFF). The cycle counter increments every cycle.
  - When the incremented count equals EXP_WOM, go to DRAIN.
  - Otherwise, if the cycle counter reaches TIMEOUT-1, go to ERR.
  - Completion has priority over timeout in the same cycle.
- DRAIN: the CPU keeps running for DRAIN_CYC cycles. wom_we still increments wom_count. Then go to DONE.
- DONE: cpu_rst=1 and done=1, held. wom_count is held.
- ERR: cpu_rst=1 and timeout_err=1, held.
- From DONE or ERR, start behaves as in IDLE: it clears done/timeout_err and wom_count next cycle and enters LOAD_PXL.
- start is ignored while busy. start and rst together: rst wins.
- Outputs are registered except src_ready. we_pxl and we_mul are never both 1.

Test Plan:
- Nominal: start, 4 quads fed back-to-back (0x1..,0x2..,0x3..,0x4..) -> we_pxl pulses pos 0,1 then we_mul pulses pos 0,1, each one cycle after its handshake. cpu_rst falls 1 cycle after the last write. After 64 wom_we pulses plus 4 cycles: done=1, cpu_rst=1, wom_count=64.
- Source stalls: src_valid low 3 cycles between each quad -> no spurious strobes; positions still 0,1,0,1; wdp/wdm match the accepted data.
- Timeout: no wom_we after load -> timeout_err=1 exactly 4096 cycles after RUN entry, cpu_rst=1. start then clears the error and reloads.
- Completion in the timeout cycle: 64th wom_we on cycle 4095 -> DRAIN then DONE, timeout_err stays 0.
- Mid-run reset: rst asserted during RUN with wom_count=20 -> next cycle IDLE, cpu_rst=1, wom_count=0, busy=0.
- start while busy: pulse start during LOAD_MUL and RUN -> no effect on state, idx or counts.

Source files
------------

// File: rtl/vector_run_ctrl.sv
// vector_run_ctrl: loads pixel and coefficient quads into the vector CPU
// register file while holding the CPU in reset. It then releases the CPU,
// counts window-output-memory writes until the expected total is reached,
// lets the pipeline drain, and reports done or timeout.
module vector_run_ctrl #(
  parameter int NUM_PXL   = 2,
  parameter int NUM_MUL   = 2,
  parameter int EXP_WOM   = 64,
  parameter int DRAIN_CYC = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         src_valid,
  input  logic [127:0] src_data,
  output logic         src_ready,
  output logic         we_pxl,
  output logic         wr_pos_pxl,
  output logic [127:0] wdp,
  output logic         we_mul,
  output logic         wr_mul_pos,
  output logic [127:0] wdm,
  output logic         cpu_rst,
  input  logic         wom_we,
  output logic [15:0]  wom_count,
  output logic         busy,
  output logic         done,
  output logic         timeout_err
);

  localparam int IDX_MAX = (NUM_PXL > NUM_MUL) ? NUM_PXL : NUM_MUL;
  localparam int IDX_W   = $clog2(IDX_MAX) + 1;
  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [IDX_W-1:0] PXL_LAST   = IDX_W'(NUM_PXL - 1);
  localparam logic [IDX_W-1:0] MUL_LAST   = IDX_W'(NUM_MUL - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [15:0]      WOM_TARGET = 16'(EXP_WOM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_PXL,
    S_LOAD_MUL,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] cyc_reg;
  logic [15:0]      wom_inc;
  logic             wom_hit;
  logic             handshake;

  // The count sticks at its maximum instead of wrapping.
  assign wom_inc   = (wom_count == 16'hFFFF) ? wom_count : wom_count + 16'd1;
  assign wom_hit   = wom_we && (wom_inc == WOM_TARGET);
  assign src_ready = (state_reg == S_LOAD_PXL) || (state_reg == S_LOAD_MUL);
  assign handshake = src_valid && src_ready;

  // Run sequencer. All outputs except src_ready are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      cyc_reg     <= '0;
      we_pxl      <= 1'b0;
      wr_pos_pxl  <= 1'b0;
      wdp         <= '0;
      we_mul      <= 1'b0;
      wr_mul_pos  <= 1'b0;
      wdm         <= '0;
      cpu_rst     <= 1'b1;
      wom_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Write strobes last exactly one cycle.
      we_pxl <= 1'b0;
      we_mul <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg   <= S_LOAD_PXL;
            idx_reg     <= '0;
            wom_count   <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            cpu_rst     <= 1'b1;
          end
        end
        S_LOAD_PXL: begin
          if (handshake) begin
            wdp        <= src_data;
            wr_pos_pxl <= idx_reg[0];
            we_pxl     <= 1'b1;
            if (idx_reg == PXL_LAST) begin
              state_reg <= S_LOAD_MUL;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        S_LOAD_MUL: begin
          if (handshake) begin
            wdm        <= src_data;
            wr_mul_pos <= idx_reg[0];
            we_mul     <= 1'b1;
            if (idx_reg == MUL_LAST) begin
              // cpu_rst stays high through the first RUN cycle so the
              // final coefficient write lands before the CPU starts.
              state_reg <= S_RUN;
              idx_reg   <= '0;
              cyc_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          cpu_rst <= 1'b0;
          cyc_reg <= cyc_reg + CNT_W'(1);
          if (wom_we) begin
            wom_count <= wom_inc;
          end
          // Completion wins over a timeout in the same cycle.
          if (wom_hit) begin
            state_reg <= S_DRAIN;
            cyc_reg   <= '0;
          end else if (cyc_reg == RUN_LAST) begin
            state_reg   <= S_ERR;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            cpu_rst     <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (wom_we) begin
            wom_count <= wom_inc;
          end
          if (cyc_reg == DRAIN_LAST) begin
            state_reg <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_rst   <= 1'b1;
          end else begin
            cyc_reg <= cyc_reg + CNT_W'(1);
            cpu_rst <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
          cpu_rst   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_run_ctrl.sv
// Bench for vector_run_ctrl: directed runs checked every cycle against a
// count-based model of a kernel run, plus hand-computed literal checks.
module tb_vector_run_ctrl;

  localparam int NQ    = 4;     // pixel + coefficient quads per run
  localparam int NPX   = 2;
  localparam int EXPW  = 64;
  localparam int DRAIN = 4;
  localparam int TMO   = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         src_valid = 1'b0;
  logic [127:0] src_data = '0;
  logic         wom_we = 1'b0;
  logic         src_ready, we_pxl, wr_pos_pxl, we_mul, wr_mul_pos, cpu_rst;
  logic [127:0] wdp, wdm;
  logic [15:0]  wom_count;
  logic         busy, done, timeout_err;

  vector_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl), .wdp(wdp),
    .we_mul(we_mul), .wr_mul_pos(wr_mul_pos), .wdm(wdm),
    .cpu_rst(cpu_rst), .wom_we(wom_we), .wom_count(wom_count),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [127:0] quads [2][NQ];

  // ---------------- model: a run described by counts ----------------
  bit           m_active = 0, m_done = 0, m_err = 0, m_cpu_rst = 1;
  bit           m_we_pxl = 0, m_we_mul = 0, m_pos_pxl = 0, m_pos_mul = 0;
  bit           m_draining = 0;
  int           m_acc = 0, m_run_cyc = 0, m_drain_left = 0;
  logic [127:0] m_wdp = '0, m_wdm = '0;
  logic [15:0]  m_wom = '0;

  initial begin
    bit was_run;
    bit hit;
    forever begin
      @(posedge clk);
      was_run  = m_active && (m_acc == NQ);
      m_we_pxl = 0;
      m_we_mul = 0;
      if (rst) begin
        m_active = 0; m_done = 0; m_err = 0; m_cpu_rst = 1;
        m_acc = 0; m_wom = '0; m_wdp = '0; m_wdm = '0;
        m_draining = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_done = 0; m_err = 0;
          m_acc = 0; m_wom = '0;
        end
      end else if (m_acc < NQ) begin
        if (src_valid) begin
          if (m_acc < NPX) begin
            m_wdp = src_data; m_pos_pxl = m_acc[0]; m_we_pxl = 1;
          end else begin
            m_wdm = src_data; m_pos_mul = m_acc[0]; m_we_mul = 1;
          end
          m_acc++;
          if (m_acc == NQ) begin
            m_run_cyc  = 0;
            m_draining = 0;
          end
        end
      end else if (!m_draining) begin
        hit = 0;
        if (wom_we) begin
          if (m_wom != 16'hFFFF) m_wom++;
          hit = (m_wom == EXPW);
        end
        if (hit) begin
          m_draining   = 1;
          m_drain_left = DRAIN;
        end else if (m_run_cyc == TMO - 1) begin
          m_active = 0;
          m_err    = 1;
        end
        m_run_cyc++;
      end else begin
        if (wom_we && m_wom != 16'hFFFF) m_wom++;
        m_drain_left--;
        if (m_drain_left == 0) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      // CPU runs only from the second run-phase cycle until the run ends.
      if (!rst) m_cpu_rst = !(was_run && m_active);
      #1;
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("timeout_err", timeout_err, m_err);
      chk("cpu_rst", cpu_rst, m_cpu_rst);
      chk("src_ready", src_ready, m_active && (m_acc < NQ));
      chk("we_pxl", we_pxl, m_we_pxl);
      chk("we_mul", we_mul, m_we_mul);
      chk("wom_count", wom_count, m_wom);
      if (m_we_pxl) begin
        chk("wr_pos_pxl", wr_pos_pxl, m_pos_pxl);
        chk("wdp", wdp, m_wdp);
      end
      if (m_we_mul) begin
        chk("wr_mul_pos", wr_mul_pos, m_pos_mul);
        chk("wdm", wdm, m_wdm);
      end
    end
  end

  // ---------------- stimulus helpers (drive after negedge) ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int gap, input bit start_mul, input int set);
    for (int q = 0; q < NQ; q++) begin
      src_valid = 1'b1;
      src_data  = quads[set][q];
      start     = start_mul && (q >= NPX);
      @(negedge clk);
      src_valid = 1'b0;
      start     = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_wom(input int n, input int gap, input bit st);
    for (int i = 0; i < n; i++) begin
      wom_we = 1'b1;
      start  = st;
      @(negedge clk);
      wom_we = 1'b0;
      start  = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_end(input int run);
    for (int i = 0; i < 40 && !(done || timeout_err); i++) @(negedge clk);
    chk("run_end_done", done, 1'b1);
    chk("run_end_count", wom_count, 16'd64);
    $display("run %0d: wom_count=%0d done=%0b timeout_err=%0b", run, wom_count, done, timeout_err);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int q = 0; q < NQ; q++) begin
      quads[0][q] = {4{32'h1111_1111 * (q + 1)}};
      quads[1][q] = {32'hA000_0004 + 32'(q << 4), 32'hA000_0003 + 32'(q << 4),
                     32'hA000_0002 + 32'(q << 4), 32'hA000_0001 + 32'(q << 4)};
    end

    repeat (2) @(negedge clk);
    chk("reset_cpu_rst", cpu_rst, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_src_ready", src_ready, 1'b0);
    chk("reset_wom_count", wom_count, 16'd0);
    chk("reset_wdp", wdp, 128'd0);
    rst = 1'b0;

    // Run 1: nominal, back-to-back load
    do_start();
    chk("start_busy", busy, 1'b1);
    chk("start_src_ready", src_ready, 1'b1);
    load(0, 0, 0);
    chk("last_we_mul", we_mul, 1'b1);
    chk("last_mul_pos", wr_mul_pos, 1'b1);
    chk("last_wdm", wdm, 128'h44444444_44444444_44444444_44444444);
    chk("last_wdp_held", wdp, 128'h22222222_22222222_22222222_22222222);
    chk("first_run_cpu_rst", cpu_rst, 1'b1);
    @(negedge clk);
    chk("released_cpu_rst", cpu_rst, 1'b0);
    pulse_wom(64, 1, 0);
    repeat (2) @(negedge clk);
    chk("drain_not_done", done, 1'b0);
    @(negedge clk);
    chk("done_after_drain", done, 1'b1);
    chk("done_cpu_rst", cpu_rst, 1'b1);
    chk("done_count", wom_count, 16'd64);
    $display("run 1: wom_count=%0d done=%0b timeout_err=%0b", wom_count, done, timeout_err);

    // Run 2: start from DONE, stalled source
    do_start();
    chk("restart_done_clear", done, 1'b0);
    chk("restart_count_clear", wom_count, 16'd0);
    load(3, 0, 1);
    chk("stall_wdp", wdp, 128'hA0000014_A0000013_A0000012_A0000011);
    pulse_wom(64, 0, 0);
    wait_end(2);

    // Run 3: start pulses while busy are ignored
    do_start();
    load(0, 1, 0);
    pulse_wom(10, 1, 1);
    chk("busy_start_count", wom_count, 16'd10);
    chk("busy_start_busy", busy, 1'b1);
    pulse_wom(54, 1, 0);
    wait_end(3);

    // Run 4: timeout with no WOM writes
    do_start();
    load(0, 0, 1);
    repeat (TMO - 1) @(negedge clk);
    chk("pre_timeout", timeout_err, 1'b0);
    @(negedge clk);
    chk("timeout_err", timeout_err, 1'b1);
    chk("timeout_cpu_rst", cpu_rst, 1'b1);
    chk("timeout_busy", busy, 1'b0);
    $display("run 4: wom_count=%0d done=%0b timeout_err=%0b", wom_count, done, timeout_err);
    do_start();
    chk("err_cleared", timeout_err, 1'b0);
    chk("err_restart_busy", busy, 1'b1);

    // Run 5: 64th write lands in the last allowed run cycle
    load(0, 0, 0);
    pulse_wom(63, 1, 0);
    repeat (TMO - 1 - 126) @(negedge clk);
    wom_we = 1'b1;
    @(negedge clk);
    wom_we = 1'b0;
    chk("edge_no_timeout", timeout_err, 1'b0);
    chk("edge_count", wom_count, 16'd64);
    chk("edge_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("edge_drain", done, 1'b0);
    @(negedge clk);
    chk("edge_done", done, 1'b1);
    chk("edge_done_no_err", timeout_err, 1'b0);
    $display("run 5: wom_count=%0d done=%0b timeout_err=%0b", wom_count, done, timeout_err);

    // Run 6: reset in the middle of RUN
    do_start();
    load(3, 0, 0);
    pulse_wom(20, 0, 0);
    chk("midrun_count", wom_count, 16'd20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_cpu_rst", cpu_rst, 1'b1);
    chk("midrun_rst_count", wom_count, 16'd0);
    $display("run 6: aborted by reset, wom_count=%0d busy=%0b", wom_count, busy);

    // start together with rst: reset wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_beats_start", busy, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
